lane_runner: RTL and testbench

- Parametrised successor to the single-lane-snap player controller. Drives the runner across NUM_LANES rails and animates lateral lane shifts over several frames.
- Queues lane commands in a small FIFO. Runs jump and slide as one explicit vertical state machine, with a minimum slide time.
- Sits between the debounced input-pulse logic and the obstacle/collision and pixel-mux logic. Produces lane, position, pose flags and per-pixel sprite-active signals.

---
 rtl/lane_runner_pkg.sv | 27 ++
 rtl/lane_runner_cmd_fifo.sv | 53 +++++
 rtl/lane_runner.sv | 214 +++++++++++++++++++++
 tb/tb_lane_runner.sv | 374 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lane_runner_pkg.sv
// Shared types, default geometry and lane-centre helper for the lane runner.
package lane_runner_pkg;

  typedef enum logic [1:0] {GROUND, RISE, FALL, SLIDE} vstate_t;

  localparam int unsigned NUM_LANES_DEF  = 3;
  localparam int unsigned LANE0_X_DEF    = 144;
  localparam int unsigned LANE_PITCH_DEF = 256;
  localparam int unsigned SHIFT_STEP_DEF = 32;
  localparam int unsigned QUEUE_DEPTH_DEF = 2;
  localparam int unsigned JUMP_HALF_DEF  = 12;
  localparam int unsigned JUMP_STEP_DEF  = 6;
  localparam int unsigned CLEAR_H_DEF    = 35;
  localparam int unsigned SLIDE_MIN_DEF  = 8;
  localparam int unsigned FEET_Y_DEF     = 480;
  localparam int unsigned PLAYER_W_DEF   = 40;
  localparam int unsigned PLAYER_H_DEF   = 50;
  localparam int unsigned SLIDE_H_DEF    = 25;
  localparam int unsigned HEAD_H_DEF     = 12;

  function automatic logic [9:0] lane_x(input int unsigned lane,
                                        input int unsigned lane0,
                                        input int unsigned pitch);
    return 10'(lane0 + lane * pitch);
  endfunction

endpackage

// File: rtl/lane_runner_cmd_fifo.sv
// Depth x 1-bit command FIFO; pushes when full and pops when empty are ignored.
module cmd_fifo #(
  parameter int unsigned DEPTH = 2
) (
  input  logic clock,
  input  logic reset_n,
  input  logic push,
  input  logic din,
  input  logic pop,
  output logic dout,
  output logic full,
  output logic empty
);

  localparam int unsigned PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CTW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] mem;
  logic [PW-1:0]    rd_ptr, wr_ptr;
  logic [CTW-1:0]   count;
  logic             do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full    = (count == CTW'(DEPTH));
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mem    <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CTW'(1);
        2'b01:   count <= count - CTW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/lane_runner.sv
// Multi-lane runner controller: queued lateral shifts, jump/slide vertical FSM, sprite pixels.
// Optional mid-air second jump enabled by defining LANE_RUNNER_DOUBLE_JUMP_EN.
module lane_runner
  import lane_runner_pkg::*;
#(
  parameter int unsigned NUM_LANES   = NUM_LANES_DEF,
  parameter int unsigned LANE0_X     = LANE0_X_DEF,
  parameter int unsigned LANE_PITCH  = LANE_PITCH_DEF,
  parameter int unsigned SHIFT_STEP  = SHIFT_STEP_DEF,
  parameter int unsigned QUEUE_DEPTH = QUEUE_DEPTH_DEF,
  parameter int unsigned JUMP_HALF   = JUMP_HALF_DEF,
  parameter int unsigned JUMP_STEP   = JUMP_STEP_DEF,
  parameter int unsigned CLEAR_H     = CLEAR_H_DEF,
  parameter int unsigned SLIDE_MIN   = SLIDE_MIN_DEF,
  parameter int unsigned FEET_Y      = FEET_Y_DEF,
  parameter int unsigned PLAYER_W    = PLAYER_W_DEF,
  parameter int unsigned PLAYER_H    = PLAYER_H_DEF,
  parameter int unsigned SLIDE_H     = SLIDE_H_DEF,
  parameter int unsigned HEAD_H      = HEAD_H_DEF
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         frame_done,
  input  logic                         game_active,
  input  logic                         move_left_pulse,
  input  logic                         move_right_pulse,
  input  logic                         jump_pulse,
  input  logic                         slide_hold,
  input  logic [9:0]                   row,
  input  logic [9:0]                   col,
  output logic [$clog2(NUM_LANES)-1:0] lane,
  output logic [9:0]                   player_x,
  output logic [9:0]                   player_y,
  output logic                         player_active,
  output logic                         player_head_active,
  output logic                         is_jumping,
  output logic                         is_sliding,
  output logic                         is_shifting,
  output logic                         jump_clear,
  output logic                         slide_clear
);

  localparam int unsigned LW = $clog2(NUM_LANES);
  localparam int unsigned CW = $clog2(JUMP_HALF + 1);
  localparam int unsigned SW = (SLIDE_MIN > 1) ? $clog2(SLIDE_MIN) : 1;
  localparam logic [LW-1:0] LANE_RST = LW'(NUM_LANES / 2);
  localparam logic [LW-1:0] LANE_MAX = LW'(NUM_LANES - 1);
  localparam logic [9:0]    XSTEP    = 10'(SHIFT_STEP);
  localparam logic [9:0]    YSTEP    = 10'(JUMP_STEP);

  logic tick;
  assign tick = frame_done & game_active;

  // ---------------- lateral: command queue and shifting ----------------
  logic          fifo_push, fifo_pop, fifo_dout, fifo_full, fifo_empty;
  logic          cmd_ok;
  logic [LW-1:0] next_lane;
  logic [9:0]    target_x;

  assign fifo_push = (move_left_pulse ^ move_right_pulse) & ~fifo_full;

  cmd_fifo #(.DEPTH(QUEUE_DEPTH)) u_cmd_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (fifo_push),
    .din     (move_right_pulse),
    .pop     (fifo_pop),
    .dout    (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign target_x    = lane_x({{(32-LW){1'b0}}, lane}, LANE0_X, LANE_PITCH);
  assign is_shifting = (player_x != target_x);
  assign fifo_pop    = tick & ~is_shifting & ~fifo_empty;
  assign cmd_ok      = fifo_dout ? (lane != LANE_MAX) : (lane != '0);
  assign next_lane   = fifo_dout ? lane + LW'(1) : lane - LW'(1);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      lane     <= LANE_RST;
      player_x <= lane_x(NUM_LANES / 2, LANE0_X, LANE_PITCH);
    end else if (tick) begin
      // Out-of-range commands are popped but leave lane and x untouched.
      if (fifo_pop && cmd_ok) begin
        lane     <= next_lane;
        player_x <= fifo_dout ? player_x + XSTEP : player_x - XSTEP;
      end else if (is_shifting) begin
        player_x <= (player_x < target_x) ? player_x + XSTEP : player_x - XSTEP;
      end
    end
  end

  // ---------------- vertical: jump latch and pose FSM ----------------
  logic jump_latch;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)        jump_latch <= 1'b0;
    else if (jump_pulse) jump_latch <= 1'b1;
    else if (frame_done) jump_latch <= 1'b0;
  end

  vstate_t       state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [SW-1:0] scnt, scnt_n;
  logic [9:0]    offset, offset_n;
`ifdef LANE_RUNNER_DOUBLE_JUMP_EN
  logic          air_used, air_used_n;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= GROUND;
      cnt      <= '0;
      scnt     <= '0;
      offset   <= '0;
`ifdef LANE_RUNNER_DOUBLE_JUMP_EN
      air_used <= 1'b0;
`endif
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      scnt     <= scnt_n;
      offset   <= offset_n;
`ifdef LANE_RUNNER_DOUBLE_JUMP_EN
      air_used <= air_used_n;
`endif
    end
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    scnt_n     = scnt;
    offset_n   = offset;
`ifdef LANE_RUNNER_DOUBLE_JUMP_EN
    air_used_n = air_used;
`endif
    if (tick) begin
      unique case (state)
        GROUND: begin
`ifdef LANE_RUNNER_DOUBLE_JUMP_EN
          air_used_n = 1'b0;
`endif
          if (jump_latch) begin
            state_n = RISE;
            cnt_n   = CW'(JUMP_HALF);
          end else if (slide_hold) begin
            state_n = SLIDE;
            scnt_n  = SW'(SLIDE_MIN - 1);
          end
        end
        RISE: begin
          offset_n = offset + YSTEP;
          if (cnt == CW'(1)) begin
            state_n = FALL;
            cnt_n   = CW'(JUMP_HALF);
          end else begin
            cnt_n = cnt - CW'(1);
          end
        end
        FALL: begin
`ifdef LANE_RUNNER_DOUBLE_JUMP_EN
          if (jump_latch && !air_used) begin
            state_n    = RISE;
            cnt_n      = CW'(JUMP_HALF);
            air_used_n = 1'b1;
          end else
`endif
          begin
            offset_n = (offset > YSTEP) ? offset - YSTEP : '0;
            if (cnt == CW'(1)) begin
              state_n  = GROUND;
              offset_n = '0;
            end else begin
              cnt_n = cnt - CW'(1);
            end
          end
        end
        SLIDE: begin
          if (scnt == '0 && !slide_hold) state_n = GROUND;
          else if (scnt != '0)           scnt_n  = scnt - SW'(1);
        end
      endcase
    end
  end

  assign is_jumping  = (state == RISE) || (state == FALL);
  assign is_sliding  = (state == SLIDE);
  assign slide_clear = is_sliding;
  assign jump_clear  = (offset >= 10'(CLEAR_H));
  assign player_y    = 10'(FEET_Y) - offset;

  // ---------------- sprite pixel windows ----------------
  logic [10:0] col_w, row_w, x_w, y_w, half_w, h_w, head_w;
  logic        in_x, in_y, in_head;

  assign col_w  = {1'b0, col};
  assign row_w  = {1'b0, row};
  assign x_w    = {1'b0, player_x};
  assign y_w    = {1'b0, player_y};
  assign half_w = 11'(PLAYER_W / 2);
  assign h_w    = is_sliding ? 11'(SLIDE_H) : 11'(PLAYER_H);
  assign head_w = 11'(HEAD_H);

  // Windows are compared with the offsets moved to the pixel side to avoid underflow.
  assign in_x    = (col_w + half_w >= x_w) && (col_w < x_w + half_w);
  assign in_y    = (row_w + h_w >= y_w) && (row_w < y_w);
  assign in_head = (row_w + h_w >= y_w) && (row_w + h_w < y_w + head_w);

  assign player_active      = game_active & in_x & in_y;
  assign player_head_active = game_active & in_x & in_y & in_head;

endmodule

// File: tb/tb_lane_runner.sv
// Self-checking bench for lane_runner: pixel table, directed sequences and random stimulus vs a frame-level model.
module tb_lane_runner;

  logic       clock = 1'b0;
  logic       reset_n, frame_done, game_active;
  logic       move_left_pulse, move_right_pulse, jump_pulse, slide_hold;
  logic [9:0] row, col;
  logic [1:0] lane;
  logic [9:0] player_x, player_y;
  logic       player_active, player_head_active;
  logic       is_jumping, is_sliding, is_shifting, jump_clear, slide_clear;

  always #5 clock = ~clock;

  lane_runner dut (
    .clock              (clock),
    .reset_n            (reset_n),
    .frame_done         (frame_done),
    .game_active        (game_active),
    .move_left_pulse    (move_left_pulse),
    .move_right_pulse   (move_right_pulse),
    .jump_pulse         (jump_pulse),
    .slide_hold         (slide_hold),
    .row                (row),
    .col                (col),
    .lane               (lane),
    .player_x           (player_x),
    .player_y           (player_y),
    .player_active      (player_active),
    .player_head_active (player_head_active),
    .is_jumping         (is_jumping),
    .is_sliding         (is_sliding),
    .is_shifting        (is_shifting),
    .jump_clear         (jump_clear),
    .slide_clear        (slide_clear)
  );

`ifdef LANE_RUNNER_DOUBLE_JUMP_EN
  localparam bit DJ = 1'b1;
`else
  localparam bit DJ = 1'b0;
`endif

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- frame-level reference model ----------------
  int m_lane, m_x, m_off, m_mode, m_t, m_base, m_slide_n;
  bit m_latch, m_used;
  bit m_q[$];

  function automatic int tx(input int l);
    return 144 + 256 * l;
  endfunction

  task automatic m_reset();
    m_lane = 1; m_x = 400; m_off = 0; m_mode = 0; m_t = 0; m_base = 0;
    m_slide_n = 0; m_latch = 0; m_used = 0;
    m_q.delete();
  endtask

  // mode: 0 ground, 1 airborne (t frames since takeoff), 2 sliding
  task automatic m_step(input bit fd, input bit ml, input bit mr, input bit jp, input bit sh);
    bit tick;
    int psize, nl, v;
    tick  = fd && game_active;
    psize = m_q.size();
    if (tick) begin
      if (m_x == tx(m_lane) && psize > 0) begin
        nl = m_q.pop_front() ? m_lane + 1 : m_lane - 1;
        if (nl >= 0 && nl < 3) begin
          m_x    = m_x + ((nl > m_lane) ? 32 : -32);
          m_lane = nl;
        end
      end else if (m_x != tx(m_lane)) begin
        m_x = m_x + ((m_x < tx(m_lane)) ? 32 : -32);
      end
    end
    if ((ml ^ mr) && psize < 2) m_q.push_back(mr);
    if (tick) begin
      case (m_mode)
        0: begin
          m_used = 0;
          if (m_latch) begin m_mode = 1; m_t = 0; m_base = 0; end
          else if (sh) begin m_mode = 2; m_slide_n = 0; end
        end
        1: begin
          if (DJ && m_t >= 12 && m_latch && !m_used) begin
            m_used = 1; m_base = m_off; m_t = 0;
          end else begin
            m_t++;
            if (m_t <= 12) m_off = m_base + 6 * m_t;
            else begin
              v = m_base + 72 - 6 * (m_t - 12);
              m_off = (v > 0) ? v : 0;
            end
            if (m_t == 24) begin m_mode = 0; m_off = 0; end
          end
        end
        default: begin
          if (m_slide_n >= 7 && !sh) m_mode = 0;
          else m_slide_n++;
        end
      endcase
    end
    if (jp) m_latch = 1;
    else if (fd) m_latch = 0;
  endtask

  task automatic check_all();
    int y, h, r, c;
    bit ea, eh;
    y  = 480 - m_off;
    h  = (m_mode == 2) ? 25 : 50;
    r  = int'(row);
    c  = int'(col);
    ea = game_active && c >= m_x - 20 && c < m_x + 20 && r >= y - h && r < y;
    eh = ea && r < y - h + 12;
    chk("lane",        int'(lane),               m_lane);
    chk("player_x",    int'(player_x),           m_x);
    chk("player_y",    int'(player_y),           y);
    chk("is_jumping",  int'(is_jumping),         int'(m_mode == 1));
    chk("is_sliding",  int'(is_sliding),         int'(m_mode == 2));
    chk("slide_clear", int'(slide_clear),        int'(m_mode == 2));
    chk("is_shifting", int'(is_shifting),        int'(m_x != tx(m_lane)));
    chk("jump_clear",  int'(jump_clear),         int'(m_off >= 35));
    chk("active",      int'(player_active),      int'(ea));
    chk("head",        int'(player_head_active), int'(eh));
  endtask

  task automatic cyc(input bit fd, input bit ml, input bit mr, input bit jp, input bit sh);
    frame_done = fd; move_left_pulse = ml; move_right_pulse = mr;
    jump_pulse = jp; slide_hold = sh;
    @(posedge clock);
    m_step(fd, ml, mr, jp, sh);
    #1;
    check_all();
  endtask

  task automatic frame_n(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(1, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    m_reset();
    check_all();
    #2;
    reset_n = 1'b1;
  endtask

  task automatic pix_chk(input int r, input int c, input bit ea, input bit eh, input string nm);
    row = 10'(r); col = 10'(c);
    #1;
    chk({nm, "_act"},  int'(player_active),      int'(ea));
    chk({nm, "_head"}, int'(player_head_active), int'(eh));
  endtask

  typedef struct {
    int row;
    int col;
    bit ga;
    bit act;
    bit head;
  } pix_t;

  pix_t ptab[10];
  int   prev, moves, peak, nclr, nsl, njmp;
  bit   sh_lvl;

  initial begin
    reset_n = 1'b0; game_active = 1'b1; row = '0; col = '0;
    frame_done = 0; move_left_pulse = 0; move_right_pulse = 0; jump_pulse = 0; slide_hold = 0;
    m_reset();

    // sprite at reset: x window [380,420), body [430,480), head [430,442)
    ptab[0] = '{479, 380, 1'b1, 1'b1, 1'b0};
    ptab[1] = '{480, 400, 1'b1, 1'b0, 1'b0};
    ptab[2] = '{430, 419, 1'b1, 1'b1, 1'b1};
    ptab[3] = '{429, 400, 1'b1, 1'b0, 1'b0};
    ptab[4] = '{441, 400, 1'b1, 1'b1, 1'b1};
    ptab[5] = '{442, 400, 1'b1, 1'b1, 1'b0};
    ptab[6] = '{450, 420, 1'b1, 1'b0, 1'b0};
    ptab[7] = '{450, 379, 1'b1, 1'b0, 1'b0};
    ptab[8] = '{435, 400, 1'b0, 1'b0, 1'b0};
    ptab[9] = '{460, 399, 1'b1, 1'b1, 1'b0};

    @(posedge clock); #1;
    do_reset();
    chk("rst_lane", int'(lane), 1);
    chk("rst_x",    int'(player_x), 400);
    chk("rst_y",    int'(player_y), 480);

    for (int i = 0; i < 10; i++) begin
      game_active = ptab[i].ga;
      row = 10'(ptab[i].row);
      col = 10'(ptab[i].col);
      cyc(0, 0, 0, 0, 0);
      chk("tab_act",  int'(player_active),      int'(ptab[i].act));
      chk("tab_head", int'(player_head_active), int'(ptab[i].head));
    end
    game_active = 1'b1;

    // single left: pop and first step on the next frame, lands on 144
    do_reset();
    cyc(0, 1, 0, 0, 0);
    prev = 400; moves = 0;
    for (int f = 1; f <= 10; f++) begin
      cyc(1, 0, 0, 0, 0);
      if (int'(player_x) != prev) moves++;
      prev = int'(player_x);
      if (f == 1) begin
        chk("left_lane", int'(lane), 0);
        chk("left_x1",   int'(player_x), 368);
      end
      cyc(0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0);
    end
    chk("left_moves", moves, 8);
    chk("left_xend",  int'(player_x), 144);

    // two lefts from lane 2, then an out-of-range left
    do_reset();
    cyc(0, 0, 1, 0, 0);
    frame_n(8);
    chk("r_x", int'(player_x), 656);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    frame_n(8);
    chk("ll_lane8", int'(lane), 1);
    chk("ll_x8",    int'(player_x), 400);
    frame_n(1);
    chk("ll_lane9", int'(lane), 0);
    chk("ll_x9",    int'(player_x), 368);
    frame_n(7);
    chk("ll_x16", int'(player_x), 144);
    cyc(0, 1, 0, 0, 0);
    frame_n(2);
    chk("oob_lane", int'(lane), 0);
    chk("oob_x",    int'(player_x), 144);
    cyc(0, 0, 1, 0, 0);
    frame_n(1);
    chk("oob_next", int'(lane), 1);

    // jump arc
    do_reset();
    cyc(0, 0, 0, 1, 0);
    frame_n(1);
    peak = 480; nclr = 0;
    for (int f = 1; f <= 24; f++) begin
      cyc(1, 0, 0, 0, 0);
      if (int'(player_y) < peak) peak = int'(player_y);
      if (jump_clear) nclr++;
      if (f == 12) chk("jump_f12_y", int'(player_y), 408);
      cyc(0, 0, 0, 0, 0);
    end
    chk("jump_peak",  peak, 408);
    chk("jump_clear", nclr, 13);
    chk("jump_land",  int'(player_y), 480);
    chk("jump_done",  int'(is_jumping), 0);

    // one-frame slide with an ignored jump
    do_reset();
    cyc(1, 0, 0, 0, 1);
    nsl = int'(is_sliding); njmp = 0;
    pix_chk(456, 400, 1'b1, 1'b1, "sl_top");
    pix_chk(454, 400, 1'b0, 1'b0, "sl_above");
    pix_chk(466, 400, 1'b1, 1'b1, "sl_head");
    pix_chk(467, 400, 1'b1, 1'b0, "sl_body");
    for (int f = 1; f <= 10; f++) begin
      cyc(1, 0, 0, 0, 0);
      nsl += int'(is_sliding);
      njmp += int'(is_jumping);
      cyc(0, 0, 0, (f == 3), 0);
      cyc(0, 0, 0, 0, 0);
    end
    chk("slide_frames", nsl, 8);
    chk("slide_nojump", njmp, 0);

    // simultaneous pulses, then queue overflow
    do_reset();
    cyc(0, 1, 1, 0, 0);
    frame_n(3);
    chk("lr_lane", int'(lane), 1);
    chk("lr_x",    int'(player_x), 400);
    cyc(0, 0, 1, 0, 0);
    frame_n(8);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    frame_n(16);
    chk("full_x", int'(player_x), 144);
    cyc(0, 0, 1, 0, 0);
    frame_n(1);
    chk("full_drop", int'(lane), 1);

    // reset in mid-jump with a queued command
    do_reset();
    cyc(0, 0, 1, 0, 0);
    frame_n(1);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 0, 1, 0);
    frame_n(8);
    chk("mid_y", int'(player_y), 438);
    do_reset();
    chk("mrst_y",    int'(player_y), 480);
    chk("mrst_jump", int'(is_jumping), 0);
    chk("mrst_lane", int'(lane), 1);
    chk("mrst_x",    int'(player_x), 400);
    frame_n(3);
    chk("mrst_fifo", int'(lane), 1);

    // air jump at falling offset 60
    do_reset();
    cyc(0, 0, 0, 1, 0);
    frame_n(15);
    chk("air_y60", int'(player_y), 420);
    cyc(0, 0, 0, 1, 0);
    frame_n(1);
`ifdef LANE_RUNNER_DOUBLE_JUMP_EN
    frame_n(12);
    chk("dj_peak", int'(player_y), 348);
`else
    chk("air_ignored", int'(player_y), 426);
`endif

    // game inactive: hold state and blank sprite
    do_reset();
    game_active = 1'b0;
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 0, 1, 0);
    frame_n(3);
    pix_chk(460, 400, 1'b0, 1'b0, "ga0");
    chk("ga0_lane", int'(lane), 1);
    chk("ga0_jump", int'(is_jumping), 0);
    game_active = 1'b1;
    frame_n(1);
    chk("ga1_lane", int'(lane), 0);
    chk("ga1_jump", int'(is_jumping), 0);

    // random stimulus against the model
    do_reset();
    sh_lvl = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 999) == 0) do_reset();
      if ($urandom_range(0, 63) == 0) game_active = ~game_active;
      if ($urandom_range(0, 23) == 0) sh_lvl = ~sh_lvl;
      row = 10'($urandom_range(380, 490));
      col = 10'($urandom_range(100, 700));
      cyc($urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
          $urandom_range(0, 19) == 0, sh_lvl);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
